// File: rtl/cc_master.sv
// Purpose : host-side master that runs one select/strobe/acknowledge transaction on the responder bus.
// Latency : accept edge ends C0, SETUP in C1, STROBE from C2; rsp_valid one cycle after ack, or after TIMEOUT strobes.
// Backpr. : req_ready is high only in IDLE, so one transaction is in flight at a time (minimum request period 4 cycles).
//
// Ports:
//   clock, reset           - sole clock; synchronous active-high reset
//   req_valid/req_ready    - host request handshake; req_write, req_data latched at accept
//   bus_m/i/k/q/p, bus_d   - responder enable, selects, direction, strobe, write data
//   resp_lanes, resp_ack   - responder read-back data and acknowledge
//   rsp_valid/data/timeout - one-cycle completion pulse, read data, abort flag
module cc_master #(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [5:0] req_data,
    output logic       req_ready,
    output logic       bus_m,
    output logic       bus_i,
    output logic       bus_k,
    output logic       bus_q,
    output logic       bus_p,
    output logic [5:0] bus_d,
    input  logic [5:0] resp_lanes,
    input  logic       resp_ack,
    output logic       rsp_valid,
    output logic [5:0] rsp_data,
    output logic       rsp_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter value seen in the last allowed strobe cycle (counter starts at 0).
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       wr_q, wr_nxt;
    logic [5:0] dat_q, dat_nxt;
    logic [5:0] rdat_nxt;
    logic       rto_nxt;
    logic       drive_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_nxt    = wr_q;
        dat_nxt   = dat_q;
        rdat_nxt  = rsp_data;
        rto_nxt   = rsp_timeout;
        case (state)
            IDLE: begin
                // req_ready is high exactly in IDLE, so req_valid alone accepts here.
                if (req_valid) begin
                    state_nxt = SETUP;
                    wr_nxt    = req_write;
                    dat_nxt   = req_data;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                cnt_nxt   = 4'd0;
            end
            STROBE: begin
                cnt_nxt = cnt + 4'd1;
                // Ack is checked before the timeout so an ack in the last strobe cycle wins.
                if (resp_ack) begin
                    state_nxt = RESP;
                    rdat_nxt  = wr_q ? 6'd0 : resp_lanes;
                    rto_nxt   = 1'b0;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = RESP;
                    rdat_nxt  = 6'd0;
                    rto_nxt   = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        drive_nxt = (state_nxt == SETUP) || (state_nxt == STROBE);
    end

    // Every output is a flop loaded from the next-state decode, so no input
    // reaches an output without passing through a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            wr_q        <= 1'b0;
            dat_q       <= 6'd0;
            req_ready   <= 1'b1;
            bus_m       <= 1'b0;
            bus_i       <= 1'b0;
            bus_k       <= 1'b0;
            bus_q       <= 1'b0;
            bus_p       <= 1'b0;
            bus_d       <= 6'd0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 6'd0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wr_q        <= wr_nxt;
            dat_q       <= dat_nxt;
            req_ready   <= (state_nxt == IDLE);
            bus_m       <= drive_nxt;
            bus_i       <= drive_nxt;
            bus_k       <= drive_nxt;
            bus_q       <= drive_nxt & wr_nxt;
            bus_p       <= (state_nxt == STROBE);
            bus_d       <= (drive_nxt && wr_nxt) ? dat_nxt : 6'd0;
            rsp_valid   <= (state_nxt == RESP);
            rsp_data    <= rdat_nxt;
            rsp_timeout <= rto_nxt;
        end
    end

endmodule

// File: tb/tb_cc_master.sv
module tb_cc_master;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    // Instance with default TIMEOUT=15
    logic       req_valid, req_write, req_ready;
    logic [5:0] req_data;
    logic       bus_m, bus_i, bus_k, bus_q, bus_p;
    logic [5:0] bus_d;
    logic [5:0] resp_lanes;
    logic       resp_ack;
    logic       rsp_valid, rsp_timeout;
    logic [5:0] rsp_data;
    // Instance with TIMEOUT=3
    logic       v3, w3, rdy3;
    logic [5:0] d3;
    logic       m3, i3, k3, q3b, p3;
    logic [5:0] bd3;
    logic [5:0] lanes3;
    logic       ack3;
    logic       rv3, rto3;
    logic [5:0] rd3;

    cc_master dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_data(req_data), .req_ready(req_ready),
        .bus_m(bus_m), .bus_i(bus_i), .bus_k(bus_k), .bus_q(bus_q), .bus_p(bus_p), .bus_d(bus_d),
        .resp_lanes(resp_lanes), .resp_ack(resp_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
    );

    cc_master #(.TIMEOUT(3)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(v3), .req_write(w3), .req_data(d3), .req_ready(rdy3),
        .bus_m(m3), .bus_i(i3), .bus_k(k3), .bus_q(q3b), .bus_p(p3), .bus_d(bd3),
        .resp_lanes(lanes3), .resp_ack(ack3),
        .rsp_valid(rv3), .rsp_data(rd3), .rsp_timeout(rto3)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] data;
        logic       to;
        int         at;
    } exp_t;
    exp_t sb15[$];
    exp_t sb3[$];

    // {req_ready, bus_m, bus_i, bus_k, bus_q, bus_p, bus_d}
    logic [10:0] bv, bv3;
    assign bv  = {req_ready, bus_m, bus_i, bus_k, bus_q, bus_p, bus_d};
    assign bv3 = {rdy3, m3, i3, k3, q3b, p3, bd3};

    function automatic logic [10:0] bvec(logic rdy, logic en, logic q, logic p, logic [5:0] d);
        return {rdy, en, en, en, q, p, d};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Response monitors: pop the expected completion whenever rsp_valid is seen.
    always @(negedge clock) begin
        if (rsp_valid === 1'b1) begin
            if (sb15.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp15 unexpected: got rsp_valid=1 at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sb15.pop_front();
                chk("rsp15 data", 32'(rsp_data), 32'(e.data));
                chk("rsp15 timeout", 32'(rsp_timeout), 32'(e.to));
                chk("rsp15 cycle", cyc, e.at);
            end
        end
    end

    always @(negedge clock) begin
        if (rv3 === 1'b1) begin
            if (sb3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp3 unexpected: got rsp_valid=1 at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sb3.pop_front();
                chk("rsp3 data", 32'(rd3), 32'(e.data));
                chk("rsp3 timeout", 32'(rto3), 32'(e.to));
                chk("rsp3 cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int c0;
        int npulse;
        int first;

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_data = 6'd0; resp_lanes = 6'd0; resp_ack = 1'b0;
        v3 = 1'b0; w3 = 1'b0; d3 = 6'd0; lanes3 = 6'd0; ack3 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        chk("reset bus", 32'(bv), 32'(bvec(1, 0, 0, 0, 6'h00)));
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset rsp_timeout", 32'(rsp_timeout), 32'd0);

        // Read with ack held high from C0
        c0 = cyc;
        req_valid = 1'b1; req_write = 1'b0; resp_ack = 1'b1; resp_lanes = 6'h2D;
        sb15.push_back('{6'h2D, 1'b0, c0 + 3});
        @(negedge clock); // C1
        req_valid = 1'b0;
        chk("read setup bus", 32'(bv), 32'(bvec(0, 1, 0, 0, 6'h00)));
        @(negedge clock); // C2
        chk("read strobe bus", 32'(bv), 32'(bvec(0, 1, 0, 1, 6'h00)));
        @(negedge clock); // C3
        resp_ack = 1'b0;
        chk("read resp bus", 32'(bv), 32'(bvec(0, 0, 0, 0, 6'h00)));
        @(negedge clock); // C4
        chk("read ready after resp", 32'(bv), 32'(bvec(1, 0, 0, 0, 6'h00)));
        chk("read data held", 32'(rsp_data), 32'h2D);

        // Back-to-back write, ack in 3rd strobe cycle
        c0 = cyc;
        req_valid = 1'b1; req_write = 1'b1; req_data = 6'h15; resp_lanes = 6'h3F;
        sb15.push_back('{6'h00, 1'b0, c0 + 5});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            chk("write bus", 32'(bv), 32'(bvec(0, 1, 1, (i > 1), 6'h15)));
            if (i == 4) resp_ack = 1'b1;
        end
        @(negedge clock); // C5
        resp_ack = 1'b0;
        chk("write resp bus", 32'(bv), 32'(bvec(0, 0, 0, 0, 6'h00)));
        @(negedge clock);

        // Read with no ack: timeout after 15 strobes
        c0 = cyc;
        req_valid = 1'b1; req_write = 1'b0; resp_lanes = 6'h2A;
        sb15.push_back('{6'h00, 1'b1, c0 + 17});
        npulse = 0;
        first = 0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (bus_p === 1'b1) begin
                npulse++;
                if (first == 0) first = i;
            end
        end
        chk("timeout strobe count", npulse, 15);
        chk("timeout first strobe", first, 2);
        @(negedge clock);

        // Ack only during IDLE and SETUP is ignored
        c0 = cyc;
        req_valid = 1'b1; resp_ack = 1'b1;
        sb15.push_back('{6'h00, 1'b1, c0 + 17});
        @(negedge clock); // C1
        req_valid = 1'b0;
        @(negedge clock); // C2
        resp_ack = 1'b0;
        repeat (16) @(negedge clock); // C18

        // Reset during the 2nd strobe cycle, with req_valid and ack pending
        req_valid = 1'b1; resp_lanes = 6'h07;
        @(negedge clock); // C1
        req_valid = 1'b0;
        @(negedge clock); // C2
        @(negedge clock); // C3
        reset = 1'b1; resp_ack = 1'b1; req_valid = 1'b1;
        @(negedge clock);
        reset = 1'b0; resp_ack = 1'b0; req_valid = 1'b0;
        chk("abort bus idle", 32'(bv), 32'(bvec(1, 0, 0, 0, 6'h00)));
        chk("abort rsp_data cleared", 32'(rsp_data), 32'd0);
        chk("abort rsp_timeout cleared", 32'(rsp_timeout), 32'd0);
        @(negedge clock);
        chk("req during reset ignored", 32'(bv), 32'(bvec(1, 0, 0, 0, 6'h00)));

        // Following read completes normally
        c0 = cyc;
        req_valid = 1'b1; resp_ack = 1'b1; resp_lanes = 6'h11;
        sb15.push_back('{6'h11, 1'b0, c0 + 3});
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resp_ack = 1'b0;
        @(negedge clock);

        // TIMEOUT=3: ack in the 3rd strobe cycle wins
        c0 = cyc;
        v3 = 1'b1; w3 = 1'b0; lanes3 = 6'h0C;
        sb3.push_back('{6'h0C, 1'b0, c0 + 5});
        @(negedge clock); // C1
        v3 = 1'b0;
        @(negedge clock); // C2
        @(negedge clock); // C3
        @(negedge clock); // C4
        chk("t3 strobe in C4", 32'(p3), 32'd1);
        ack3 = 1'b1;
        @(negedge clock); // C5
        ack3 = 1'b0;
        @(negedge clock);

        // TIMEOUT=3: ack first seen where a 4th strobe would be -> timeout
        c0 = cyc;
        v3 = 1'b1; lanes3 = 6'h33;
        sb3.push_back('{6'h00, 1'b1, c0 + 5});
        @(negedge clock); // C1
        v3 = 1'b0;
        repeat (4) @(negedge clock); // C5
        chk("t3 no 4th strobe", 32'(p3), 32'd0);
        ack3 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        ack3 = 1'b0;
        repeat (4) @(negedge clock);
        chk("t3 idle after late ack", 32'(bv3), 32'(bvec(1, 0, 0, 0, 6'h00)));

        chk("sb15 drained", sb15.size(), 0);
        chk("sb3 drained", sb3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_master.md
CC_MASTER -- requirements
Module: cc_master

Interface
REQ-001 Parameter TIMEOUT, default 15, strobe cycles to wait for acknowledge before abort; legal range 1..15.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_write  input  1  1 = write transaction, 0 = read.
REQ-006 req_data  input  6  write data; ignored for reads.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 bus_m  output  1  bus enable to responder.
REQ-009 bus_i  output  1  select line I.
REQ-010 bus_k  output  1  select line K; responder addressed only when bus_i and bus_k are both high.
REQ-011 bus_q  output  1  direction, 1 = write.
REQ-012 bus_p  output  1  transfer strobe.
REQ-013 bus_d  output  6  write data lanes to responder.
REQ-014 resp_lanes  input  6  responder read-back lanes.
REQ-015 resp_ack  input  1  responder acknowledge.
REQ-016 rsp_valid  output  1  one-cycle completion pulse to host.
REQ-017 rsp_data  output  6  captured read data.
REQ-018 rsp_timeout  output  1  completion was an abort; qualified by rsp_valid.

Function
REQ-019 FSM states IDLE, SETUP, STROBE, RESP; IDLE is the only state with req_ready=1.
REQ-020 Accept = req_valid & req_ready at a rising edge; the edge latches req_write and req_data and moves IDLE->SETUP.
REQ-021 SETUP lasts exactly one cycle: bus_m=bus_i=bus_k=1, bus_q=latched direction, bus_p=0; then ->STROBE unconditionally.
REQ-022 STROBE: same bus drive as SETUP plus bus_p=1; 4-bit strobe counter cleared on SETUP->STROBE and incremented each STROBE cycle.
REQ-023 resp_ack is sampled only in STROBE; resp_ack during IDLE, SETUP or RESP is ignored.
REQ-024 resp_ack=1 in a STROBE cycle -> RESP next cycle; for a read, resp_lanes are captured into rsp_data on that edge; for a write, rsp_data=0.
REQ-025 No ack by the end of the TIMEOUT-th STROBE cycle -> RESP with rsp_timeout=1, rsp_data=0.
REQ-026 Ack in the TIMEOUT-th STROBE cycle wins over timeout (rsp_timeout=0).
REQ-027 RESP lasts exactly one cycle: rsp_valid=1, all bus_* outputs 0; then ->IDLE.
REQ-028 rsp_data and rsp_timeout hold their value until the next RESP; rsp_valid=0 outside RESP.
REQ-029 bus_d = latched write data in SETUP and STROBE of a write; 0 in all other cases, including reads.
REQ-030 All bus_* outputs are 0 in IDLE and RESP.
REQ-031 Latency: accept edge ends cycle C0; SETUP=C1, first STROBE=C2; ack in C2 gives rsp_valid in C3; with TIMEOUT=15 and no ack, rsp_valid in C17.
REQ-032 Back-to-back: req_ready is 1 in the cycle after RESP, so the minimum request period is 4 cycles.
REQ-033 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-034 reset=1 at a rising edge forces IDLE, clears the counter, latched direction and data, rsp_data, rsp_timeout and rsp_valid, and drives all bus_* outputs to 0; req_ready=1 the cycle after reset deasserts.
REQ-035 Reset in SETUP or STROBE aborts the transaction with no rsp_valid pulse; a pending resp_ack is discarded.
REQ-036 req_valid asserted while reset=1 is not accepted.

Verification
REQ-037 Read, ack held high from C0: bus_i=bus_k=bus_m=1 and bus_p=0 in C1, bus_p=1 in C2; resp_lanes=6'h2D -> rsp_valid=1, rsp_data=6'h2D, rsp_timeout=0 in C3; req_ready=1 in C4.
REQ-038 Write req_data=6'h15, ack raised in the 3rd STROBE cycle: bus_q=1 and bus_d=6'h15 in C1..C4; rsp_valid in C5 with rsp_data=0; bus_d=0 in C5.
REQ-039 Read, no ack, TIMEOUT=15: bus_p=1 for exactly 15 cycles (C2..C16); rsp_valid=1, rsp_timeout=1, rsp_data=0 in C17.
REQ-040 TIMEOUT=3, ack first seen in the 3rd STROBE cycle: rsp_timeout=0 and data captured; ack first seen in the 4th STROBE cycle: timeout reported and the ack ignored.
REQ-041 Reset pulsed during the 2nd STROBE cycle: all bus_* outputs 0 and req_ready=1 after reset deasserts, no rsp_valid; a following read completes normally.
REQ-042 resp_ack=1 during IDLE and SETUP only, low during STROBE: no early completion; timeout reported.
